// File: rtl/mem_arbiter_if.sv
// Signal bundle around mem_arbiter: fetch port, data port and the shared memory command/data path.
// Handshake: a requester raises *_req with its command stable and keeps it high until the matching
// *_ready pulse; *_ready is a one-cycle completion strobe, never a stall, and read data is valid with it.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;

    logic        ma_req;
    logic        ma_we;
    logic [2:0]  ma_mode;
    logic [31:0] ma_addr;
    logic [31:0] ma_wdata;
    logic        ma_ready;
    logic [31:0] ma_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [2:0]  mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Arbiter view.
    modport slave (
        input  if_req, if_addr,
        input  ma_req, ma_we, ma_mode, ma_addr, ma_wdata,
        input  mem_rdata,
        output if_ready, if_rdata,
        output ma_ready, ma_rdata,
        output mem_en, mem_we, mem_mode, mem_addr, mem_wdata
    );

    // Core and memory view.
    modport master (
        output if_req, if_addr,
        output ma_req, ma_we, ma_mode, ma_addr, ma_wdata,
        output mem_rdata,
        input  if_ready, if_rdata,
        input  ma_ready, ma_rdata,
        input  mem_en, mem_we, mem_mode, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-ported memory between the fetch (IF)
// and memory-access (MA) ports; one access in flight at a time, read data returned per port.
module mem_arbiter #(
    parameter int unsigned LAT = 2  // read latency in cycles, legal 1..7
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        P_IF = 1'b0,
        P_MA = 1'b1
    } port_t;

    localparam logic [2:0] CNT_INIT   = 3'(LAT - 1);
    localparam logic [2:0] FETCH_MODE = 3'b010;

    state_t      state_q, state_d;
    port_t       owner_q, owner_d;
    port_t       last_q, last_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic        cmd_we_q, cmd_we_d;
    logic [2:0]  mem_mode_q, mem_mode_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] ma_rdata_q, ma_rdata_d;
    logic        if_ready_q, if_ready_d;
    logic        ma_ready_q, ma_ready_d;

    logic        grant_if;
    logic        grant_ma;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        cmd_we_d    = cmd_we_q;
        mem_mode_d  = mem_mode_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        ma_rdata_d  = ma_rdata_q;
        if_ready_d  = 1'b0;
        ma_ready_d  = 1'b0;
        grant_if    = 1'b0;
        grant_ma    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // On a conflict the port that did not win last time goes first.
                grant_ma = bus.ma_req && (!bus.if_req || (last_q == P_IF));
                grant_if = bus.if_req && !grant_ma;
                if (grant_ma) begin
                    owner_d     = P_MA;
                    last_d      = P_MA;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.ma_we;
                    cmd_we_d    = bus.ma_we;
                    mem_mode_d  = bus.ma_mode;
                    mem_addr_d  = bus.ma_addr;
                    mem_wdata_d = bus.ma_wdata;
                    state_d     = S_ISSUE;
                end else if (grant_if) begin
                    owner_d     = P_IF;
                    last_d      = P_IF;
                    mem_en_d    = 1'b1;
                    cmd_we_d    = 1'b0;
                    mem_mode_d  = FETCH_MODE;
                    mem_addr_d  = bus.if_addr;
                    state_d     = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // The registered command is on the memory pins this cycle.
                if (cmd_we_q) begin
                    ma_ready_d = (owner_q == P_MA);
                    if_ready_d = (owner_q == P_IF);
                    state_d    = S_RESP;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    if (owner_q == P_MA) begin
                        ma_rdata_d = bus.mem_rdata;
                        ma_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = bus.mem_rdata;
                        if_ready_d = 1'b1;
                    end
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            owner_q     <= P_IF;
            last_q      <= P_IF;
            cnt_q       <= 3'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            cmd_we_q    <= 1'b0;
            mem_mode_q  <= 3'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            if_rdata_q  <= 32'd0;
            ma_rdata_q  <= 32'd0;
            if_ready_q  <= 1'b0;
            ma_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            cmd_we_q    <= cmd_we_d;
            mem_mode_q  <= mem_mode_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            ma_rdata_q  <= ma_rdata_d;
            if_ready_q  <= if_ready_d;
            ma_ready_q  <= ma_ready_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_mode  = mem_mode_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ma_ready  = ma_ready_q;
    assign bus.ma_rdata  = ma_rdata_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: LAT=2 instance gets vectors, corner sequences and random traffic;
// LAT=1 and LAT=7 instances get latency probes. A memory model returns garbage off the valid cycle.
module tb_mem_arbiter;

    localparam int BOUND = 40;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if b2 ();
    mem_arbiter_if b1 ();
    mem_arbiter_if b7 ();

    logic [1:0] st2, st1, st7;

    mem_arbiter #(.LAT(2)) dut2 (.clk(clk), .reset(reset), .bus(b2), .dbg_state(st2));
    mem_arbiter #(.LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1), .dbg_state(st1));
    mem_arbiter #(.LAT(7)) dut7 (.clk(clk), .reset(reset), .bus(b7), .dbg_state(st7));

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int en_count = 0;
    int en_cyc   = -1;
    logic [31:0] en_addr, en_wdata;
    logic        en_we;
    logic [2:0]  en_mode;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;

    typedef struct {
        logic        is_ma;
        logic        we;
        logic [2:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_lat;
        logic [31:0] exp_rdata;
    } vec_t;

    pend_t       pend_q[3][$];
    logic [31:0] mem_img [logic [31:0]];
    logic [31:0] shadow  [logic [31:0]];
    logic [31:0] if_exp_q[$];
    logic [31:0] ma_exp_q[$];
    logic [31:0] rd_m2, rd_m1, rd_m7;
    vec_t        vecs[7];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] img_rd(input logic [31:0] a);
        return mem_img.exists(a) ? mem_img[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : dflt(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Fixed-latency memory: data only in the cycle LAT after the command, random otherwise.
    task automatic mem_side(input int idx, input int lat, input logic en, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rd);
        pend_t p;
        rd = $urandom;
        if (pend_q[idx].size() > 0 && pend_q[idx][0].due == cyc) begin
            rd = img_rd(pend_q[idx][0].addr);
            void'(pend_q[idx].pop_front());
        end
        if (en === 1'b1 && we === 1'b1) mem_img[addr] = wdata;
        if (en === 1'b1 && we === 1'b0) begin
            p.due  = cyc + lat;
            p.addr = addr;
            pend_q[idx].push_back(p);
        end
    endtask

    always @(negedge clk) begin
        mem_side(0, 2, b2.mem_en, b2.mem_we, b2.mem_addr, b2.mem_wdata, rd_m2);
        mem_side(1, 1, b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata, rd_m1);
        mem_side(2, 7, b7.mem_en, b7.mem_we, b7.mem_addr, b7.mem_wdata, rd_m7);
        b2.mem_rdata = rd_m2;
        b1.mem_rdata = rd_m1;
        b7.mem_rdata = rd_m7;
        if (b2.mem_en === 1'b1) begin
            en_count++;
            en_cyc   = cyc;
            en_addr  = b2.mem_addr;
            en_we    = b2.mem_we;
            en_mode  = b2.mem_mode;
            en_wdata = b2.mem_wdata;
        end
        if (b2.mem_we === 1'b1) check("mem_we_only_with_en", 32'(b2.mem_en), 32'd1);
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drivers: called just after a rising edge; return just after the edge following ready.
    task automatic run_if(input logic [31:0] addr, output int lat, output logic [31:0] rd);
        b2.if_addr = addr;
        b2.if_req  = 1'b1;
        lat = -1;
        rd  = 32'd0;
        for (int k = 0; k <= BOUND; k++) begin
            @(negedge clk);
            if (b2.if_ready === 1'b1) begin
                lat = k;
                rd  = b2.if_rdata;
                break;
            end
            tick();
        end
        tick();
        b2.if_req = 1'b0;
    endtask

    task automatic run_ma(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rd);
        b2.ma_we    = we;
        b2.ma_mode  = mode;
        b2.ma_addr  = addr;
        b2.ma_wdata = wdata;
        b2.ma_req   = 1'b1;
        lat = -1;
        rd  = 32'd0;
        for (int k = 0; k <= BOUND; k++) begin
            @(negedge clk);
            if (b2.ma_ready === 1'b1) begin
                lat = k;
                rd  = b2.ma_rdata;
                break;
            end
            tick();
        end
        tick();
        b2.ma_req = 1'b0;
    endtask

    task automatic probe(input int which, input logic [31:0] addr, output int lat,
                         output logic [31:0] rd);
        if (which == 1) begin
            b1.ma_addr = addr; b1.ma_we = 1'b0; b1.ma_mode = 3'd2; b1.ma_req = 1'b1;
        end else begin
            b7.ma_addr = addr; b7.ma_we = 1'b0; b7.ma_mode = 3'd2; b7.ma_req = 1'b1;
        end
        lat = -1;
        rd  = 32'd0;
        for (int k = 0; k <= BOUND; k++) begin
            @(negedge clk);
            if ((which == 1 ? b1.ma_ready : b7.ma_ready) === 1'b1) begin
                lat = k;
                rd  = (which == 1) ? b1.ma_rdata : b7.ma_rdata;
                break;
            end
            tick();
        end
        tick();
        b1.ma_req = 1'b0;
        b7.ma_req = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        b2.if_req = 1'b0; b2.ma_req = 1'b0;
        b1.if_req = 1'b0; b1.ma_req = 1'b0;
        b7.if_req = 1'b0; b7.ma_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        int          start;
        int          en0;
        int          n_if, n_ma;
        int          evq[$];
        int          got;

        reset = 1'b0;
        b2.if_req = 1'b0; b2.if_addr = 32'd0; b2.ma_req = 1'b0; b2.ma_we = 1'b0;
        b2.ma_mode = 3'd0; b2.ma_addr = 32'd0; b2.ma_wdata = 32'd0; b2.mem_rdata = 32'd0;
        b1.if_req = 1'b0; b1.if_addr = 32'd0; b1.ma_req = 1'b0; b1.ma_we = 1'b0;
        b1.ma_mode = 3'd0; b1.ma_addr = 32'd0; b1.ma_wdata = 32'd0; b1.mem_rdata = 32'd0;
        b7.if_req = 1'b0; b7.if_addr = 32'd0; b7.ma_req = 1'b0; b7.ma_we = 1'b0;
        b7.ma_mode = 3'd0; b7.ma_addr = 32'd0; b7.ma_wdata = 32'd0; b7.mem_rdata = 32'd0;

        mem_img[32'h100] = 32'h0050_0093; shadow[32'h100] = 32'h0050_0093;
        mem_img[32'h104] = 32'h00A0_0113; shadow[32'h104] = 32'h00A0_0113;
        mem_img[32'h108] = 32'h00B0_0193; shadow[32'h108] = 32'h00B0_0193;
        mem_img[32'h300] = 32'hCAFE_F00D; shadow[32'h300] = 32'hCAFE_F00D;

        vecs[0] = '{1'b0, 1'b0, 3'd0, 32'h0000_0100, 32'h0,         4, 32'h0050_0093};
        vecs[1] = '{1'b1, 1'b1, 3'd0, 32'h0000_0200, 32'hDEAD_BEEF, 2, 32'h0000_0000};
        vecs[2] = '{1'b1, 1'b0, 3'd2, 32'h0000_0200, 32'h0,         4, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b1, 3'd2, 32'h0000_0204, 32'h1234_5678, 2, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 1'b0, 3'd0, 32'h0000_0104, 32'h0,         4, 32'h00A0_0113};
        vecs[5] = '{1'b1, 1'b0, 3'd1, 32'h0000_0204, 32'h0,         4, 32'h1234_5678};
        vecs[6] = '{1'b1, 1'b0, 3'd4, 32'h0000_0300, 32'h0,         4, 32'hCAFE_F00D};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_if_ready",  32'(b2.if_ready), 32'd0);
        check("rst_ma_ready",  32'(b2.ma_ready), 32'd0);
        check("rst_if_rdata",  b2.if_rdata, 32'd0);
        check("rst_ma_rdata",  b2.ma_rdata, 32'd0);
        check("rst_mem_en",    32'(b2.mem_en), 32'd0);
        check("rst_mem_we",    32'(b2.mem_we), 32'd0);
        check("rst_mem_mode",  32'(b2.mem_mode), 32'd0);
        check("rst_mem_addr",  b2.mem_addr, 32'd0);
        check("rst_mem_wdata", b2.mem_wdata, 32'd0);
        check("rst_state2",    32'(st2), 32'd0);
        check("rst_state1",    32'(st1), 32'd0);
        check("rst_state7",    32'(st7), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Single transactions from idle
        for (int i = 0; i < 7; i++) begin
            start = cyc;
            en0   = en_count;
            if (vecs[i].is_ma)
                run_ma(vecs[i].we, vecs[i].mode, vecs[i].addr, vecs[i].wdata, lat, rd);
            else
                run_if(vecs[i].addr, lat, rd);
            if (vecs[i].is_ma && vecs[i].we) shadow[vecs[i].addr] = vecs[i].wdata;
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_en_count", i), 32'(en_count - en0), 32'd1);
            check($sformatf("vec%0d_en_cycle", i), 32'(en_cyc - start), 32'd1);
            check($sformatf("vec%0d_mem_addr", i), en_addr, vecs[i].addr);
            check($sformatf("vec%0d_mem_we", i), 32'(en_we), 32'(vecs[i].is_ma & vecs[i].we));
            check($sformatf("vec%0d_mem_mode", i), 32'(en_mode),
                  32'(vecs[i].is_ma ? vecs[i].mode : 3'b010));
            if (vecs[i].is_ma && vecs[i].we)
                check($sformatf("vec%0d_mem_wdata", i), en_wdata, vecs[i].wdata);
            tick();
        end

        // Address change after grant has no effect
        b2.if_addr = 32'h100;
        b2.if_req  = 1'b1;
        lat = -1;
        rd  = 32'd0;
        for (int k = 0; k <= BOUND; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("addrchg_mem_en", 32'(b2.mem_en), 32'd1);
                check("addrchg_mem_addr", b2.mem_addr, 32'h100);
            end
            if (b2.if_ready === 1'b1) begin
                lat = k;
                rd  = b2.if_rdata;
                break;
            end
            tick();
            if (k == 1) b2.if_addr = 32'h104;
        end
        tick();
        b2.if_req = 1'b0;
        check("addrchg_latency", 32'(lat), 32'd4);
        check("addrchg_rdata", rd, 32'h0050_0093);
        check("addrchg_mem_addr_hold", b2.mem_addr, 32'h100);
        tick();

        // Dropped after grant completes; dropped before grant is never serviced
        en0  = en_count;
        n_if = 0;
        n_ma = 0;
        lat  = -1;
        b2.if_addr = 32'h108;
        b2.if_req  = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (b2.if_ready === 1'b1) begin
                n_if++;
                lat = k;
                check("drop_if_rdata", b2.if_rdata, 32'h00B0_0193);
            end
            if (b2.ma_ready === 1'b1) n_ma++;
            tick();
            if (k == 0) begin
                b2.if_req = 1'b0;
                b2.ma_we = 1'b0; b2.ma_addr = 32'h300; b2.ma_mode = 3'd2; b2.ma_req = 1'b1;
            end
            if (k == 2) b2.ma_req = 1'b0;
        end
        check("drop_if_ready_count", 32'(n_if), 32'd1);
        check("drop_if_latency", 32'(lat), 32'd4);
        check("drop_ma_ready_count", 32'(n_ma), 32'd0);
        check("drop_en_count", 32'(en_count - en0), 32'd1);

        // Conflict right after reset: MA first, then strict alternation
        do_reset();
        b2.ma_we = 1'b0; b2.ma_mode = 3'd2; b2.ma_addr = 32'h300; b2.if_addr = 32'h104;
        b2.ma_req = 1'b1;
        b2.if_req = 1'b1;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            if (b2.ma_ready === 1'b1) begin
                evq.push_back(1000 + k);
                check("conflict_ma_rdata", b2.ma_rdata, 32'hCAFE_F00D);
            end
            if (b2.if_ready === 1'b1) begin
                evq.push_back(k);
                check("conflict_if_rdata", b2.if_rdata, 32'h00A0_0113);
            end
            tick();
            if (k + 1 == 20) begin
                b2.ma_req = 1'b0;
                b2.if_req = 1'b0;
            end
        end
        check("conflict_event_count", 32'(evq.size()), 32'd4);
        for (int n = 0; n < 4; n++) begin
            got = (n < evq.size()) ? evq[n] : -1;
            check($sformatf("conflict_event%0d", n), 32'(got),
                  32'(((n % 2 == 0) ? 1000 : 0) + n * (2 + 3) + 2 + 2));
        end

        // Reset in the middle of a read
        b2.if_addr = 32'h100;
        b2.if_req  = 1'b1;
        tick();
        tick();
        reset     = 1'b0;
        b2.if_req = 1'b0;
        #1;
        check("midrst_mem_en",   32'(b2.mem_en), 32'd0);
        check("midrst_mem_addr", b2.mem_addr, 32'd0);
        check("midrst_mem_mode", 32'(b2.mem_mode), 32'd0);
        check("midrst_if_rdata", b2.if_rdata, 32'd0);
        check("midrst_ma_rdata", b2.ma_rdata, 32'd0);
        check("midrst_state",    32'(st2), 32'd0);
        n_if = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (b2.if_ready === 1'b1 || b2.ma_ready === 1'b1) n_if++;
            tick();
        end
        check("midrst_no_ready", 32'(n_if), 32'd0);
        reset = 1'b1;
        run_if(32'h104, lat, rd);
        check("postrst_latency", 32'(lat), 32'd4);
        check("postrst_rdata", rd, 32'h00A0_0113);

        // Latency extremes
        probe(1, 32'h104, lat, rd);
        check("lat1_latency", 32'(lat), 32'd3);
        check("lat1_rdata", rd, ref_rd(32'h104));
        probe(1, 32'h2A0, lat, rd);
        check("lat1_rdata_dflt", rd, ref_rd(32'h2A0));
        probe(7, 32'h100, lat, rd);
        check("lat7_latency", 32'(lat), 32'd9);
        check("lat7_rdata", rd, ref_rd(32'h100));
        probe(7, 32'h3C4, lat, rd);
        check("lat7_rdata_dflt", rd, ref_rd(32'h3C4));

        // Random traffic on both ports of the LAT=2 instance
        en0 = en_count;
        fork
            begin : if_proc
                int          l;
                logic [31:0] r;
                logic [31:0] a;
                for (int t = 0; t < 25; t++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    a = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
                    if_exp_q.push_back(ref_rd(a));
                    run_if(a, l, r);
                    check("rand_if_latency", 32'(l >= 4 && l <= 2 * 2 + 6), 32'd1);
                    check("rand_if_rdata", r, if_exp_q.pop_front());
                end
            end
            begin : ma_proc
                int          l;
                logic [31:0] r;
                logic [31:0] a;
                logic [31:0] w;
                logic        we;
                logic [31:0] last_rd;
                last_rd = 32'd0;
                for (int t = 0; t < 25; t++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    we = (t == 0) ? 1'b0 : 1'($urandom_range(0, 1));
                    a  = 32'h2000 + (32'($urandom_range(0, 15)) << 2);
                    w  = $urandom;
                    if (we) begin
                        shadow[a] = w;
                        ma_exp_q.push_back(last_rd);
                    end else begin
                        ma_exp_q.push_back(ref_rd(a));
                        last_rd = ref_rd(a);
                    end
                    run_ma(we, 3'($urandom_range(0, 7)), a, w, l, r);
                    check("rand_ma_latency",
                          32'(l >= (we ? 2 : 4) && l <= 2 * 2 + 6), 32'd1);
                    check("rand_ma_rdata", r, ma_exp_q.pop_front());
                end
            end
        join
        check("rand_en_count", 32'(en_count - en0), 32'd50);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported, fixed-latency unified memory between the pipeline's instruction-fetch (IF) port and memory-access (MA) port. Each requester holds a request until a one-cycle ready pulse; the arbiter latches the command, drives the memory, times the read latency, and returns read data on a per-port register. Conflicts are resolved round-robin so neither port starves. The block sits between the core's `pc`/`instr` and `rwam`/`wdm`/`rdm`/`wem`/`rwmm` ports and the memory.

## Interface

- `LAT`, default 2: memory read latency in cycles, from the command cycle to the data-valid cycle; legal range 1..7.

- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; 0 clears all state immediately.
- `if_req` in 1: fetch request; held high until `if_ready`.
- `if_addr` in 32: fetch address.
- `if_ready` out 1: one-cycle completion pulse for the fetch port.
- `if_rdata` out 32: fetched instruction.
- `ma_req` in 1: data request; held high until `ma_ready`.
- `ma_we` in 1: 1 selects a store, 0 selects a load.
- `ma_mode` in 3: access mode (funct3 encoding), passed through to memory.
- `ma_addr` in 32: data address.
- `ma_wdata` in 32: store data.
- `ma_ready` out 1: one-cycle completion pulse for the data port.
- `ma_rdata` out 32: load data.
- `mem_en` out 1: command strobe, high for exactly one cycle per access.
- `mem_we` out 1: write enable; valid only while `mem_en` is high.
- `mem_mode` out 3: access mode.
- `mem_addr` out 32: access address.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data; valid in the cycle `LAT` cycles after the `mem_en` cycle.

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESP. Registers: `owner` (IF/MA), `last` (last granted port), 3-bit down-counter `cnt`, latched command, `if_rdata`, `ma_rdata`.
- IDLE samples the requests:
  - Only one request high: grant that port.
  - Both high: grant the port that is not `last`.
  - On grant: latch the command (IF grants have `we`=0 and `mode`=3'b010), set `owner` and `last`, go to ISSUE.
  - Neither high: stay in IDLE.
- ISSUE:
  - `mem_en`=1 and `mem_*` = latched command.
  - Store: go to RESP.
  - Load or fetch: load `cnt`=LAT-1, go to WAIT.
- WAIT:
  - `cnt`≠0: decrement `cnt`.
  - `cnt`=0: capture `mem_rdata` into the owner's rdata register, go to RESP.
- RESP: assert the owner's ready for one cycle, go to IDLE. Requests are not sampled in RESP.
- Output encoding:
  - `mem_*` outputs are registered. `mem_we`/`mem_mode`/`mem_addr`/`mem_wdata` hold the last command between accesses. `mem_we` is 0 outside ISSUE.
  - `if_rdata` and `ma_rdata` hold their last captured value until the next capture for that port. A store never changes `ma_rdata`.
- Protocol rules:
  - A requester must not change its address, data or mode while waiting. Because the command is latched, changes after the grant have no effect.
  - A request dropped before its grant is simply not serviced.
  - A request dropped after its grant still completes, and its ready pulse is still issued.
- Reset values (`reset`=0): state=IDLE, `last`=IF (so MA wins the first conflict), `cnt`=0, all outputs 0 including both rdata registers and all `mem_*` outputs. An in-flight access is abandoned with no ready pulse, and memory data returning after reset is ignored.

## Timing

- Request first high in IDLE cycle c:
  - `mem_en` in c+1.
  - Read: `mem_rdata` sampled at the end of c+LAT+1; ready and rdata valid in c+LAT+2.
  - Store: ready in c+2.
- Next request sampling happens in c+LAT+3 for a read, or c+3 for a store. Throughput is one access per LAT+3 cycles for reads and one per 3 cycles for stores.
- Back-to-back conflict: ports alternate strictly, e.g. MA, IF, MA, IF with both requests held high.
- Reset deassertion takes effect at the next rising edge. The first grant is possible in the first cycle after deassertion.

## Test plan

- LAT=2, lone fetch: `if_req`=1, `if_addr`=0x100 in cycle 0; memory returns 0x00500093 in cycle 3 -> `mem_en` only in cycle 1 with `mem_addr`=0x100, `mem_we`=0; `if_ready`=1 and `if_rdata`=0x00500093 in cycle 4 only.
- Store: `ma_req`=1, `ma_we`=1, `ma_addr`=0x200, `ma_wdata`=0xDEADBEEF, `ma_mode`=0 -> cycle 1 `mem_en`=`mem_we`=1 with those values; `ma_ready` in cycle 2 only; `ma_rdata` unchanged.
- Conflict after reset: both requests held high from cycle 0 -> MA granted first (`ma_ready` cycle 4), IF granted in cycle 5 (`if_ready` cycle 9), then MA again.
- Reset mid-read: drive `reset`=0 during WAIT -> all outputs 0 immediately; no ready pulse; a later `if_req` completes normally with latency 4.
- LAT=1 and LAT=7 loads -> ready at c+3 and c+9 respectively; data captured exactly from the valid cycle (memory drives garbage on other cycles).
- Address change after grant: change `if_addr` in cycle 2 -> `mem_addr` showed the original address in cycle 1, and the result matches the original address.
